// File: rtl/tetris_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tetris_ctrl_pkg
// Shared definitions for the move-request producer feeding the game-logic FSM.
//   - command index constants.  The index order is also the grant priority,
//     lowest index first: Drop > Left > Right > Down.
//   - issuer FSM state encodings
//   - default timing constants for CLOCK_50 (50 MHz)
//   - pick_winner(): priority pick of one pending command
// Optional build macro AUTO_REPEAT_EN adds the auto-repeat timing defaults.
// -----------------------------------------------------------------------------
package tetris_ctrl_pkg;

   localparam int NUM_CMDS  = 4;
   localparam int CMD_DROP  = 0;
   localparam int CMD_LEFT  = 1;
   localparam int CMD_RIGHT = 2;
   localparam int CMD_DOWN  = 3;

   localparam int DEF_GRAV_DIV        = 25_000_000;  // 0.5 s gravity period
   localparam int DEF_DEBOUNCE_CYCLES = 500_000;     // 10 ms key stability
`ifdef AUTO_REPEAT_EN
   localparam int DEF_REPEAT_DELAY    = 15_000_000;  // 300 ms before first repeat
   localparam int DEF_REPEAT_CYCLES   = 5_000_000;   // 100 ms repeat period
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_RELEASE = 2'd2
   } issuer_state_t;

   // One-hot of the highest-priority set bit. Index 0 (Drop) wins first,
   // matching the consumer's decode order.
   function automatic logic [NUM_CMDS-1:0] pick_winner(input logic [NUM_CMDS-1:0] pend);
      logic [NUM_CMDS-1:0] win;
      win = '0;
      for (int k = 0; k < NUM_CMDS; k++) begin
         if (pend[k] && (win == '0)) win[k] = 1'b1;
      end
      return win;
   endfunction

endpackage

// File: rtl/move_command_issuer_if.sv
// -----------------------------------------------------------------------------
// move_command_issuer_if
// Move-request handshake between the command issuer (master) and the
// game-logic FSM (slave).
//   checkBoard                               request valid
//   DropBlock/LeftBlock/RightBlock/DownBlock one-hot command, valid only while
//                                            checkBoard=1
//   doneLogic                                completion strobe from the FSM
// Handshake: the master raises checkBoard with exactly one command bit and
// holds both unchanged until it samples doneLogic=1 on a clock edge; that edge
// completes the transfer and the command is still valid in that cycle. The
// master then drives checkBoard and all commands low for at least one cycle
// before the next request. doneLogic while checkBoard=0 has no effect.
// -----------------------------------------------------------------------------
interface move_command_issuer_if;
   logic checkBoard;
   logic DropBlock;
   logic LeftBlock;
   logic RightBlock;
   logic DownBlock;
   logic doneLogic;

   modport master (
      output checkBoard, DropBlock, LeftBlock, RightBlock, DownBlock,
      input  doneLogic
   );

   modport slave (
      input  checkBoard, DropBlock, LeftBlock, RightBlock, DownBlock,
      output doneLogic
   );
endinterface

// File: rtl/move_command_issuer_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchroniser, stability filter and rising-edge pulse for one key.
// Optional build macro AUTO_REPEAT_EN: while the filtered key stays high, a
// further pulse is produced REPEAT_DELAY cycles after the press and then every
// REPEAT_CYCLES cycles (only when REPEAT_ALLOW=1).
// Ports:
//   CLOCK_50  in  system clock
//   Resetn    in  synchronous active-low reset
//   i_key     in  raw asynchronous key, active-high
//   o_pulse   out one-cycle pulse per accepted press (and per repeat)
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
`ifdef AUTO_REPEAT_EN
   , parameter int REPEAT_DELAY  = 10
   , parameter int REPEAT_CYCLES = 3
   , parameter bit REPEAT_ALLOW  = 1'b1
`endif
) (
   input  logic CLOCK_50,
   input  logic Resetn,
   input  logic i_key,
   output logic o_pulse
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_stable;
   logic            r_pulse;
   logic [DB_W-1:0] r_db_cnt;
   logic            w_accept;
   logic            w_rise;
   logic            w_rep_fire;

   // The synchronised key must disagree with the accepted level for
   // DEBOUNCE_CYCLES consecutive cycles before the accepted level follows it.
   assign w_accept = (r_sync2 != r_stable) && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
   assign w_rise   = w_accept && r_sync2;

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_db_cnt <= '0;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_db_cnt <= '0;
         end else if (w_accept) begin
            r_stable <= r_sync2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   logic            r_rep_phase;  // 0 = waiting first delay, 1 = periodic
   logic [RP_W-1:0] r_rep_cnt;

   // The counter starts at 0 in the first cycle the key is accepted high, so
   // the first repeat pulse lands exactly REPEAT_DELAY cycles after the press pulse.
   always_comb begin
      w_rep_fire = 1'b0;
      if (REPEAT_ALLOW && r_stable) begin
         if (r_rep_phase) w_rep_fire = (r_rep_cnt == RP_W'(REPEAT_CYCLES - 1));
         else             w_rep_fire = (r_rep_cnt == RP_W'(REPEAT_DELAY - 1));
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn || !r_stable) begin
         r_rep_phase <= 1'b0;
         r_rep_cnt   <= '0;
      end else if (w_rep_fire) begin
         r_rep_phase <= 1'b1;
         r_rep_cnt   <= '0;
      end else begin
         r_rep_cnt   <= r_rep_cnt + 1'b1;
      end
   end
`else
   assign w_rep_fire = 1'b0;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) r_pulse <= 1'b0;
      else         r_pulse <= w_rise | w_rep_fire;
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/move_command_issuer.sv
// -----------------------------------------------------------------------------
// move_command_issuer
// Producer side of the move-request handshake into the game-logic FSM.
// Debounces the four player keys, runs the gravity timer, keeps one pending
// flag per command and issues one request at a time (checkBoard plus a
// one-hot command) until the FSM answers with doneLogic.
// Optional build macro AUTO_REPEAT_EN: Left/Right/Down auto-repeat while held
// (adds parameters REPEAT_DELAY and REPEAT_CYCLES).
// Ports:
//   CLOCK_50          in  system clock
//   Resetn            in  synchronous active-low reset
//   KeyDrop/KeyLeft/KeyRight/KeyDown  in  raw keys, active-high, asynchronous
//   GameRun           in  1 = grant requests and run gravity, 0 = paused
//   finishedDrawing   in  display idle; a new request is granted only when 1
//   busy              out 1 whenever the FSM is not IDLE
//   o_dbg_state       out current FSM state
//   cmd_if            master side of the move-request handshake
// -----------------------------------------------------------------------------
module move_command_issuer
   import tetris_ctrl_pkg::*;
#(
   parameter int GRAV_DIV        = DEF_GRAV_DIV,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef AUTO_REPEAT_EN
   , parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY
   , parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
`endif
) (
   input  logic                  CLOCK_50,
   input  logic                  Resetn,
   input  logic                  KeyDrop,
   input  logic                  KeyLeft,
   input  logic                  KeyRight,
   input  logic                  KeyDown,
   input  logic                  GameRun,
   input  logic                  finishedDrawing,
   output logic                  busy,
   output issuer_state_t         o_dbg_state,
   move_command_issuer_if.master cmd_if
);

   localparam int GRAV_W = $clog2(GRAV_DIV + 1);

   issuer_state_t       r_state, w_state_next;
   logic [NUM_CMDS-1:0] r_pending;
   logic [NUM_CMDS-1:0] r_cmd, w_cmd_next;
   logic                r_check, w_check_next;
   logic [GRAV_W-1:0]   r_grav_cnt;
   logic                w_grav_tick;
   logic [NUM_CMDS-1:0] w_keys;
   logic [NUM_CMDS-1:0] w_pulse;
   logic [NUM_CMDS-1:0] w_set;
   logic [NUM_CMDS-1:0] w_clr;
   logic [NUM_CMDS-1:0] w_grant;

   assign w_keys[CMD_DROP]  = KeyDrop;
   assign w_keys[CMD_LEFT]  = KeyLeft;
   assign w_keys[CMD_RIGHT] = KeyRight;
   assign w_keys[CMD_DOWN]  = KeyDown;

   for (genvar g = 0; g < NUM_CMDS; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
         , .REPEAT_DELAY  (REPEAT_DELAY)
         , .REPEAT_CYCLES (REPEAT_CYCLES)
         , .REPEAT_ALLOW  (g != CMD_DROP)
`endif
      ) u_db (
         .CLOCK_50 (CLOCK_50),
         .Resetn   (Resetn),
         .i_key    (w_keys[g]),
         .o_pulse  (w_pulse[g])
      );
   end

   // Gravity: free-running while GameRun=1, frozen while paused.
   assign w_grav_tick = GameRun && (r_grav_cnt == GRAV_W'(GRAV_DIV - 1));

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         r_grav_cnt <= '0;
      end else if (GameRun) begin
         if (w_grav_tick) r_grav_cnt <= '0;
         else             r_grav_cnt <= r_grav_cnt + 1'b1;
      end
   end

   always_comb begin
      w_set           = w_pulse;
      w_set[CMD_DOWN] = w_pulse[CMD_DOWN] | w_grav_tick;
   end

   // A set arriving in the same cycle as the clear of that flag survives,
   // so a press landing on a grant is never lost.
   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) r_pending <= '0;
      else         r_pending <= (r_pending & ~w_clr) | w_set;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         r_state <= ST_IDLE;
         r_cmd   <= '0;
         r_check <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cmd   <= w_cmd_next;
         r_check <= w_check_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cmd_next   = r_cmd;
      w_check_next = r_check;
      w_grant      = '0;
      w_clr        = '0;
      case (r_state)
         ST_IDLE: begin
            w_cmd_next   = '0;
            w_check_next = 1'b0;
            if (GameRun && finishedDrawing && (|r_pending)) begin
               w_grant = pick_winner(r_pending);
               w_clr   = w_grant;
               // A drop lands the piece, so a queued Down is stale.
               if (w_grant[CMD_DROP]) w_clr[CMD_DOWN] = 1'b1;
               w_cmd_next   = w_grant;
               w_check_next = 1'b1;
               w_state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (cmd_if.doneLogic) begin
               w_cmd_next   = '0;
               w_check_next = 1'b0;
               w_state_next = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            // One low cycle lets the consumer leave its completion state.
            w_cmd_next   = '0;
            w_check_next = 1'b0;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_cmd_next   = '0;
            w_check_next = 1'b0;
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign cmd_if.checkBoard = r_check;
   assign cmd_if.DropBlock  = r_cmd[CMD_DROP];
   assign cmd_if.LeftBlock  = r_cmd[CMD_LEFT];
   assign cmd_if.RightBlock = r_cmd[CMD_RIGHT];
   assign cmd_if.DownBlock  = r_cmd[CMD_DOWN];
   assign busy              = (r_state != ST_IDLE);
   assign o_dbg_state       = r_state;

endmodule
